// File: rtl/approx_mult_pkg.sv
// ---------------------------------------------------------------------------
// approx_mult_pkg
// Shared definitions for the approximate multiplier pipeline.
//   prodWidth(w)    : product width for w-bit operands (2*w)
//   STAGES          : pipeline depth of approx_mult_pipe
//   colHeight(k, w) : number of partial-product bits that land in column k
//                     of a w x w unsigned multiplication
// ---------------------------------------------------------------------------
package approx_mult_pkg;

  localparam int STAGES = 3;

  function automatic int prodWidth(input int w);
    return 2 * w;
  endfunction

  // Columns 0..w-1 grow by one bit per column, columns w..2w-2 shrink again,
  // and the top column 2w-1 only ever receives carries.
  function automatic int colHeight(input int k, input int w);
    if ((k < 0) || (k > 2 * w - 2)) begin
      return 0;
    end
    if (k < w) begin
      return k + 1;
    end
    return 2 * w - 1 - k;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// ---------------------------------------------------------------------------
// approx_mult_pipe_if
// Streaming interface of approx_mult_pipe: operand side (in_*) and result
// side (out_*), each with a valid/ready handshake.
//   master : producer of operands / consumer of results
//   slave  : the multiplier itself
// Optional macro APPROX_ERR_MON_EN adds out_err (exact product - out_p).
// ---------------------------------------------------------------------------
interface approx_mult_pipe_if
  import approx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int TAG_W = 4
);

  localparam int PW = prodWidth(W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_exact;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_p;
  logic [TAG_W-1:0] out_tag;
`ifdef APPROX_ERR_MON_EN
  logic [PW-1:0]    out_err;

  modport master (
    output in_valid, in_a, in_b, in_exact, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_exact, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, out_err
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_exact, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_exact, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag
  );
`endif

endinterface

// File: rtl/approx_col_reducer.sv
// ---------------------------------------------------------------------------
// approx_col_reducer
// Combinational partial-product reduction to a two-row (sum/carry) result.
//   i_pp    : partial-product matrix, i_pp[i][j] = b[i] & a[j] (weight i+j)
//   i_exact : 1 = reduce every column exactly
//   o_sum   : sum row, 2W bits
//   o_carry : carry row, 2W bits; o_sum + o_carry is the product
// Columns below APPROX_COLS are OR-compressed to a single bit (unless i_exact)
// and therefore never produce carries; the remaining columns go through a
// carry-save array of full adders.
// ---------------------------------------------------------------------------
module approx_col_reducer
  import approx_mult_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_COLS = 8
) (
  input  logic [W-1:0][W-1:0]        i_pp,
  input  logic                       i_exact,
  output logic [prodWidth(W)-1:0]    o_sum,
  output logic [prodWidth(W)-1:0]    o_carry
);

  localparam int PW = prodWidth(W);

  logic [PW-1:0] w_colOr;
  logic [PW-1:0] w_approxCol;

  // OR of every partial-product bit in each column. Row LO is the lowest row
  // that owns a bit in column k; walking up the rows walks down the columns
  // of operand a.
  for (genvar k = 0; k < PW; k++) begin : g_col
    localparam int H  = colHeight(k, W);
    localparam int LO = (k < W) ? 0 : k - W + 1;
    if (H > 0) begin : g_bits
      logic [H-1:0] w_bits;
      for (genvar h = 0; h < H; h++) begin : g_bit
        assign w_bits[h] = i_pp[LO+h][k-LO-h];
      end
      assign w_colOr[k] = |w_bits;
    end else begin : g_empty
      assign w_colOr[k] = 1'b0;
    end
  end

  // Column mode select: the low block is approximate unless the transaction
  // asked for an exact product.
  always_comb begin
    w_approxCol = '0;
    for (int k = 0; k < PW; k++) begin
      w_approxCol[k] = (k < APPROX_COLS) && !i_exact;
    end
  end

  // Carry-save accumulation. The OR row seeds the sum row; every exact row is
  // masked out of the approximate columns, so those columns only ever hold a
  // single nonzero bit and no carry can be generated into or out of them.
  // The carry out of the top column is dropped: the true total fits in 2W.
  always_comb begin
    logic [PW-1:0] row;
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] t;
    row = '0;
    s   = w_colOr & w_approxCol;
    c   = '0;
    for (int i = 0; i < W; i++) begin
      row = (PW'(i_pp[i]) << i) & ~w_approxCol;
      t   = s ^ c ^ row;
      c   = ((s & c) | (s & row) | (c & row)) << 1;
      s   = t;
    end
    o_sum   = s;
    o_carry = c;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// ---------------------------------------------------------------------------
// approx_mult_pipe
// Three-stage pipelined unsigned approximate multiplier with per-transaction
// exact/approximate mode and valid/ready streaming on both sides.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, flushes every stage
//   bus   : approx_mult_pipe_if slave (in_* operands, out_* results)
// Stages: S1 partial-product matrix, S2 sum/carry rows, S3 final product.
// Optional macro APPROX_ERR_MON_EN carries the exact product down the pipe
// and drives out_err = exact - out_p alongside out_p.
// ---------------------------------------------------------------------------
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_COLS = 8,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  approx_mult_pipe_if.slave bus
);

  localparam int PW = prodWidth(W);

  logic                  r_s1Valid;
  logic [W-1:0][W-1:0]   r_s1Pp;
  logic                  r_s1Exact;
  logic [TAG_W-1:0]      r_s1Tag;

  logic                  r_s2Valid;
  logic [PW-1:0]         r_s2Sum;
  logic [PW-1:0]         r_s2Carry;
  logic [TAG_W-1:0]      r_s2Tag;

  logic                  r_s3Valid;
  logic [PW-1:0]         r_s3P;
  logic [TAG_W-1:0]      r_s3Tag;

  logic                  w_s1Adv;
  logic                  w_s2Adv;
  logic                  w_s3Adv;
  logic [W-1:0][W-1:0]   w_pp;
  logic [PW-1:0]         w_sum;
  logic [PW-1:0]         w_carry;
  logic [PW-1:0]         w_finalP;

  // Backpressure chain: a stage may take new data when it is empty or its
  // current contents move on this cycle. Only valids and out_ready feed it.
  assign w_s3Adv     = !r_s3Valid || bus.out_ready;
  assign w_s2Adv     = !r_s2Valid || w_s3Adv;
  assign w_s1Adv     = !r_s1Valid || w_s2Adv;
  assign bus.in_ready = w_s1Adv;

  // Partial-product matrix: row i is operand a gated by bit i of operand b.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < W; i++) begin
      w_pp[i] = bus.in_b[i] ? bus.in_a : '0;
    end
  end

  // S1 captures the matrix, mode and tag whenever it is allowed to advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Pp    <= '0;
      r_s1Exact <= 1'b0;
      r_s1Tag   <= '0;
    end else if (w_s1Adv) begin
      r_s1Valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1Pp    <= w_pp;
        r_s1Exact <= bus.in_exact;
        r_s1Tag   <= bus.in_tag;
      end
    end
  end

  approx_col_reducer #(
    .W           (W),
    .APPROX_COLS (APPROX_COLS)
  ) u_reducer (
    .i_pp    (r_s1Pp),
    .i_exact (r_s1Exact),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // S2 holds the compressed two-row form of the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Sum   <= '0;
      r_s2Carry <= '0;
      r_s2Tag   <= '0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Sum   <= w_sum;
        r_s2Carry <= w_carry;
        r_s2Tag   <= r_s1Tag;
      end
    end
  end

  assign w_finalP = r_s2Sum + r_s2Carry;

  // S3 is the output register; it only reloads when the result has been
  // taken (or was never valid), so a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3Valid <= 1'b0;
      r_s3P     <= '0;
      r_s3Tag   <= '0;
    end else if (w_s3Adv) begin
      r_s3Valid <= r_s2Valid;
      if (r_s2Valid) begin
        r_s3P   <= w_finalP;
        r_s3Tag <= r_s2Tag;
      end
    end
  end

  assign bus.out_valid = r_s3Valid;
  assign bus.out_p     = r_s3P;
  assign bus.out_tag   = r_s3Tag;

`ifdef APPROX_ERR_MON_EN
  logic [PW-1:0] r_s1Prod;
  logic [PW-1:0] r_s2Prod;
  logic [PW-1:0] r_s3Err;

  // Error monitor: the exact product rides along with the same enables as
  // the main datapath. In exact mode w_finalP equals the product, so the
  // reported error is zero without any special casing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Prod <= '0;
      r_s2Prod <= '0;
      r_s3Err  <= '0;
    end else begin
      if (w_s1Adv && bus.in_valid) begin
        r_s1Prod <= PW'(bus.in_a) * PW'(bus.in_b);
      end
      if (w_s2Adv && r_s1Valid) begin
        r_s2Prod <= r_s1Prod;
      end
      if (w_s3Adv && r_s2Valid) begin
        r_s3Err <= r_s2Prod - w_finalP;
      end
    end
  end

  assign bus.out_err = r_s3Err;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_approx_mult_pipe
// Self-checking bench for approx_mult_pipe (W=8, APPROX_COLS=8, TAG_W=4)
// plus a second fully exact instance (APPROX_COLS=0).
// Honours APPROX_ERR_MON_EN to check out_err as well.
// ---------------------------------------------------------------------------
module tb_approx_mult_pipe;

  localparam int W  = 8;
  localparam int AC = 8;
  localparam int TW = 4;
  localparam int PW = 2 * W;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          exact;
    logic [TW-1:0] tag;
    logic [PW-1:0] expP;
    logic [PW-1:0] expErr;
  } vec_t;

  typedef struct {
    logic [PW-1:0] p;
    logic [PW-1:0] err;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;

  int   checks     = 0;
  int   errors     = 0;
  int   outCount   = 0;
  int   outCountEx = 0;
  exp_t sbQ[$];
  exp_t sbQEx[$];
  exp_t curExp;
  exp_t curExpEx;
  vec_t vecs[13];
  bit   acc;
  bit   fire;

  approx_mult_pipe_if #(.W(W), .TAG_W(TW)) bus ();
  approx_mult_pipe_if #(.W(W), .TAG_W(TW)) busEx ();

  approx_mult_pipe #(.W(W), .APPROX_COLS(AC), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  approx_mult_pipe #(.W(W), .APPROX_COLS(0), .TAG_W(TW)) dutEx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busEx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Column-by-column reference: count the pp bits of each column, OR them in
  // the approximate region, add them at full weight elsewhere.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ex, input int ac);
    logic [63:0] total;
    int          cnt;
    total = 64'd0;
    for (int k = 0; k < PW; k++) begin
      cnt = 0;
      for (int i = 0; i < W; i++) begin
        for (int j = 0; j < W; j++) begin
          if ((i + j == k) && a[j] && b[i]) cnt++;
        end
      end
      if (!ex && (k < ac)) total += (cnt > 0) ? (64'd1 << k) : 64'd0;
      else                 total += 64'(cnt) << k;
    end
    return total[PW-1:0];
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal("out_p", 64'(bus.out_p), 64'(e.p));
    checkVal("out_tag", 64'(bus.out_tag), 64'(e.tag));
`ifdef APPROX_ERR_MON_EN
    checkVal("out_err", 64'(bus.out_err), 64'(e.err));
`endif
  endtask

  // One clock: account for handshakes at the negedge, then move to just
  // after the next rising edge where the caller may drive new inputs.
  task automatic cycle(output bit inAcc, output bit outFire);
    exp_t e;
    bit   exIn;
    @(negedge clk);
    inAcc   = bus.in_valid && bus.in_ready;
    outFire = bus.out_valid && bus.out_ready;
    exIn    = busEx.in_valid && busEx.in_ready;
    if (outFire) begin
      outCount++;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got tag %0d p %0d, required no output",
                 bus.out_tag, bus.out_p);
      end else begin
        e = sbQ.pop_front();
        checkOutput(e);
      end
    end
    if (busEx.out_valid && busEx.out_ready) begin
      outCountEx++;
      if (sbQEx.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output_ex: got p %0d, required no output", busEx.out_p);
      end else begin
        e = sbQEx.pop_front();
        checkVal("ex_out_p", 64'(busEx.out_p), 64'(e.p));
        checkVal("ex_out_tag", 64'(busEx.out_tag), 64'(e.tag));
      end
    end
    if (inAcc) sbQ.push_back(curExp);
    if (exIn)  sbQEx.push_back(curExpEx);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, output bit inAcc);
    bit f;
    bus.in_valid = 1'b1;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_exact = v.exact;
    bus.in_tag   = v.tag;
    curExp       = '{p: v.expP, err: v.expErr, tag: v.tag};
    cycle(inAcc, f);
    bus.in_valid = 1'b0;
  endtask

  task automatic driveModel(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ex, input logic [TW-1:0] tag);
    logic [PW-1:0] p;
    logic [PW-1:0] full;
    p            = model(a, b, ex, AC);
    full         = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_exact = ex;
    bus.in_tag   = tag;
    curExp       = '{p: p, err: full - p, tag: tag};
  endtask

  initial begin
    int            lat;
    int            accepts;
    int            base;
    bit            haveRef;
    logic [PW-1:0] refP;
    logic [TW-1:0] refTag;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;

    vecs[0]  = '{a: 8'd255, b: 8'd255, exact: 1'b0, tag: 4'd1,  expP: 16'd63487, expErr: 16'd1538};
    vecs[1]  = '{a: 8'd255, b: 8'd255, exact: 1'b1, tag: 4'd2,  expP: 16'd65025, expErr: 16'd0};
    vecs[2]  = '{a: 8'd3,   b: 8'd3,   exact: 1'b0, tag: 4'd3,  expP: 16'd7,     expErr: 16'd2};
    vecs[3]  = '{a: 8'd3,   b: 8'd5,   exact: 1'b0, tag: 4'd4,  expP: 16'd15,    expErr: 16'd0};
    vecs[4]  = '{a: 8'd0,   b: 8'd200, exact: 1'b0, tag: 4'd5,  expP: 16'd0,     expErr: 16'd0};
    vecs[5]  = '{a: 8'd0,   b: 8'd0,   exact: 1'b1, tag: 4'd6,  expP: 16'd0,     expErr: 16'd0};
    vecs[6]  = '{a: 8'd15,  b: 8'd15,  exact: 1'b0, tag: 4'd7,  expP: 16'd127,   expErr: 16'd98};
    vecs[7]  = '{a: 8'd15,  b: 8'd15,  exact: 1'b1, tag: 4'd8,  expP: 16'd225,   expErr: 16'd0};
    vecs[8]  = '{a: 8'd16,  b: 8'd16,  exact: 1'b0, tag: 4'd9,  expP: 16'd256,   expErr: 16'd0};
    vecs[9]  = '{a: 8'd128, b: 8'd255, exact: 1'b0, tag: 4'd10, expP: 16'd32640, expErr: 16'd0};
    vecs[10] = '{a: 8'd200, b: 8'd100, exact: 1'b1, tag: 4'd11, expP: 16'd20000, expErr: 16'd0};
    vecs[11] = '{a: 8'd255, b: 8'd1,   exact: 1'b0, tag: 4'd12, expP: 16'd255,   expErr: 16'd0};
    vecs[12] = '{a: 8'd6,   b: 8'd6,   exact: 1'b0, tag: 4'd13, expP: 16'd28,    expErr: 16'd8};

    bus.in_valid    = 1'b0;
    bus.in_a        = '0;
    bus.in_b        = '0;
    bus.in_exact    = 1'b0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b1;
    busEx.in_valid  = 1'b0;
    busEx.in_a      = '0;
    busEx.in_b      = '0;
    busEx.in_exact  = 1'b0;
    busEx.in_tag    = '0;
    busEx.out_ready = 1'b1;
    curExp          = '{p: '0, err: '0, tag: '0};
    curExpEx        = '{p: '0, err: '0, tag: '0};

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkVal("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("reset_out_p", 64'(bus.out_p), 64'd0);
    checkVal("reset_out_tag", 64'(bus.out_tag), 64'd0);
    checkVal("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkVal("reset_ex_out_valid", 64'(busEx.out_valid), 64'd0);
`ifdef APPROX_ERR_MON_EN
    checkVal("reset_out_err", 64'(bus.out_err), 64'd0);
`endif
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v], acc);
      checkVal($sformatf("vec%0d_accept", v), 64'(acc), 64'd1);
      lat = 0;
      for (int n = 1; n <= 8 && lat == 0; n++) begin
        cycle(acc, fire);
        if (fire) lat = n;
      end
      checkVal($sformatf("vec%0d_latency", v), 64'(lat), 64'd3);
    end

    $display("[TB] back-to-back stream");
    base = outCount;
    for (int i = 0; i < 20; i++) begin
      driveModel(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), i[TW-1:0]);
      cycle(acc, fire);
      checkVal("stream_accept", 64'(acc), 64'd1);
      if (i >= 3) checkVal("stream_throughput", 64'(fire), 64'd1);
    end
    bus.in_valid = 1'b0;
    for (int n = 0; n < 8 && sbQ.size() != 0; n++) cycle(acc, fire);
    checkVal("stream_drained", 64'(sbQ.size()), 64'd0);
    checkVal("stream_count", 64'(outCount - base), 64'd20);

    $display("[TB] output stall");
    base          = outCount;
    accepts       = 0;
    haveRef       = 1'b0;
    refP          = '0;
    refTag        = '0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ra = W'(23 + 37 * accepts);
      rb = W'(250 - 29 * accepts);
      driveModel(ra, rb, accepts[0], TW'(8 + accepts));
      cycle(acc, fire);
      if (acc) accepts++;
      if (bus.out_valid) begin
        if (!haveRef) begin
          haveRef = 1'b1;
          refP    = bus.out_p;
          refTag  = bus.out_tag;
        end else begin
          checkVal("stall_hold_p", 64'(bus.out_p), 64'(refP));
          checkVal("stall_hold_tag", 64'(bus.out_tag), 64'(refTag));
        end
      end
    end
    checkVal("stall_accepts", 64'(accepts), 64'd3);
    checkVal("stall_in_ready", 64'(bus.in_ready), 64'd0);
    checkVal("stall_out_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 8 && sbQ.size() != 0; n++) cycle(acc, fire);
    checkVal("stall_drained", 64'(sbQ.size()), 64'd0);
    checkVal("stall_count", 64'(outCount - base), 64'd3);

    $display("[TB] reset with transactions in flight");
    for (int i = 0; i < 3; i++) begin
      driveModel(W'(100 + i), W'(77 + i), 1'b0, TW'(i + 1));
      cycle(acc, fire);
    end
    bus.in_valid = 1'b0;
    checkVal("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("midreset_out_p", 64'(bus.out_p), 64'd0);
    checkVal("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    sbQ.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = outCount;
    for (int n = 0; n < 6; n++) cycle(acc, fire);
    checkVal("post_reset_no_output", 64'(outCount - base), 64'd0);

    $display("[TB] fully exact instance");
    base = outCountEx;
    for (int i = 0; i < 100; i++) begin
      ra               = W'($urandom_range(0, 255));
      rb               = W'($urandom_range(0, 255));
      busEx.in_valid   = 1'b1;
      busEx.in_a       = ra;
      busEx.in_b       = rb;
      busEx.in_exact   = 1'($urandom_range(0, 1));
      busEx.in_tag     = i[TW-1:0];
      curExpEx         = '{p: {{W{1'b0}}, ra} * {{W{1'b0}}, rb}, err: '0, tag: i[TW-1:0]};
      cycle(acc, fire);
    end
    busEx.in_valid = 1'b0;
    for (int n = 0; n < 8 && sbQEx.size() != 0; n++) cycle(acc, fire);
    checkVal("exact_drained", 64'(sbQEx.size()), 64'd0);
    checkVal("exact_count", 64'(outCountEx - base), 64'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
